// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the seqmult arbiter slice.
package mult_arb_pkg;

   localparam int OP_W        = 4;
   localparam int PROD_W      = 8;
   localparam int DEF_TIMEOUT = 15;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_e;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mult_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after the previous winner.
module rr_pick
   import mult_arb_pkg::*;
#(
   parameter int  N_REQ = 4,
   localparam int IDW   = idx_w(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [IDW-1:0]   last_i,
   output logic [N_REQ-1:0] oh_o,
   output logic [IDW-1:0]   idx_o,
   output logic             vld_o
);

   logic [IDW-1:0] pos;

   // Walk the ring starting one past last_i; the final step wraps back to last_i itself.
   always_comb begin
      oh_o  = '0;
      idx_o = '0;
      vld_o = 1'b0;
      pos   = last_i;
      for (int k = 0; k < N_REQ; k++) begin
         pos = (pos == IDW'(N_REQ - 1)) ? '0 : pos + 1'b1;
         if (!vld_o && req_i[pos]) begin
            vld_o     = 1'b1;
            oh_o[pos] = 1'b1;
            idx_o     = pos;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Arbitrates N_REQ requesters onto one external seqmult, with a WAIT timeout.
//   state    | meaning
//   ST_IDLE  | no operation; arbitrate when any req is high
//   ST_ISSUE | one cycle: gnt to winner, mul_load pulse to seqmult
//   ST_WAIT  | waiting for mul_ready; abort after TIMEOUT cycles
module mult_arbiter
   import mult_arb_pkg::*;
#(
   parameter int  N_REQ   = 4,
   parameter int  TIMEOUT = DEF_TIMEOUT,
   localparam int IDW     = idx_w(N_REQ),
   localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic                  clk,
   input  logic                  rst_a,
   input  logic [N_REQ-1:0]      req,
   input  logic [OP_W*N_REQ-1:0] a_in,
   input  logic [OP_W*N_REQ-1:0] b_in,
   output logic [N_REQ-1:0]      gnt,
   output logic [PROD_W-1:0]     res,
   output logic                  res_valid,
   output logic [IDW-1:0]        res_id,
   output logic                  res_err,
   output logic                  busy,
   output logic [OP_W-1:0]       mul_a,
   output logic [OP_W-1:0]       mul_b,
   output logic                  mul_load,
   input  logic [PROD_W-1:0]     mul_op,
   input  logic                  mul_ready
);

   arb_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic              load_q, load_d;
   logic [OP_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
   logic [PROD_W-1:0] res_q, res_d;
   logic [IDW-1:0]    res_id_q, res_id_d, last_q, last_d;
   logic              valid_q, valid_d, err_q, err_d, busy_q, busy_d;

   logic [N_REQ-1:0]  pick_oh;
   logic [IDW-1:0]    pick_idx;
   logic              pick_vld;
   logic [OP_W-1:0]   sel_a, sel_b;

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .req_i  (req),
      .last_i (last_q),
      .oh_o   (pick_oh),
      .idx_o  (pick_idx),
      .vld_o  (pick_vld)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_oh[i]) begin
            sel_a = a_in[i*OP_W +: OP_W];
            sel_b = b_in[i*OP_W +: OP_W];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_d    = '0;
      load_d   = 1'b0;
      mul_a_d  = mul_a_q;
      mul_b_d  = mul_b_q;
      res_d    = res_q;
      res_id_d = res_id_q;
      last_d   = last_q;
      valid_d  = 1'b0;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               state_d  = ST_ISSUE;
               gnt_d    = pick_oh;
               load_d   = 1'b1;
               mul_a_d  = sel_a;
               mul_b_d  = sel_b;
               res_id_d = pick_idx;
               last_d   = pick_idx;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
            cnt_d   = '0;
         end
         ST_WAIT: begin
            // A ready arriving on the timeout cycle still counts as a real result.
            if (mul_ready) begin
               state_d = ST_IDLE;
               res_d   = mul_op;
               err_d   = 1'b0;
               valid_d = 1'b1;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               state_d = ST_IDLE;
               res_d   = '0;
               err_d   = 1'b1;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst_a) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         gnt_q    <= '0;
         load_q   <= 1'b0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         res_q    <= '0;
         res_id_q <= '0;
         last_q   <= IDW'(N_REQ - 1);
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         load_q   <= load_d;
         mul_a_q  <= mul_a_d;
         mul_b_q  <= mul_b_d;
         res_q    <= res_d;
         res_id_q <= res_id_d;
         last_q   <= last_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign gnt       = gnt_q;
   assign mul_load  = load_q;
   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign res       = res_q;
   assign res_id    = res_id_q;
   assign res_valid = valid_q;
   assign res_err   = err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural seqmult of programmable delay.
module tb_mult_arbiter;

   localparam int NR = 4;
   localparam int TO = 15;

   logic          clk, rst_a;
   logic [NR-1:0] req, gnt;
   logic [15:0]   a_in, b_in;
   logic [7:0]    res, mul_op;
   logic          res_valid, res_err, busy, mul_load, mul_ready;
   logic [1:0]    res_id;
   logic [3:0]    mul_a, mul_b;

   mult_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_a     (rst_a),
      .req       (req),
      .a_in      (a_in),
      .b_in      (b_in),
      .gnt       (gnt),
      .res       (res),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_err   (res_err),
      .busy      (busy),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_load  (mul_load),
      .mul_op    (mul_op),
      .mul_ready (mul_ready)
   );

   typedef struct {
      int res;
      int id;
      int err;
      int busy;
      int cyc;
   } rrec_t;

   int    n_cmp = 0, n_bad = 0;
   int    cyc = 0, n_load = 0, viol = 0;
   int    gq[$], gcq[$];
   rrec_t rq[$];
   int    mdl_dly, mdl_cnt;
   logic  [3:0] mdl_a, mdl_b;
   logic  [7:0] hold_ab;
   logic  drop;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // seqmult model: mdl_dly cycles after the load cycle, one-cycle ready; 0 means never.
   initial begin
      mul_ready = 1'b0;
      mul_op    = 8'hA5;
      mdl_cnt   = 0;
      mdl_a     = '0;
      mdl_b     = '0;
      forever begin
         @(posedge clk);
         #1;
         mul_ready = 1'b0;
         mul_op    = 8'hA5;
         if (rst_a) begin
            mdl_cnt = 0;
         end else if (mul_load) begin
            mdl_cnt = mdl_dly;
            mdl_a   = mul_a;
            mdl_b   = mul_b;
         end else if (mdl_cnt > 0) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
               mul_ready = 1'b1;
               mul_op    = 8'(mdl_a) * 8'(mdl_b);
            end
         end
      end
   end

   // Monitor: grant and result logs plus structural invariants.
   initial begin
      hold_ab = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (gnt != '0) begin
            for (int i = 0; i < NR; i++)
               if (gnt[i]) gq.push_back(i);
            gcq.push_back(cyc);
            if ($countones(gnt) != 1) viol++;
         end
         if (mul_load != (gnt != '0)) viol++;
         if (mul_load) n_load++;
         if (mul_load) hold_ab = {mul_a, mul_b};
         else if (busy && ({mul_a, mul_b} != hold_ab)) viol++;
         if (res_valid)
            rq.push_back('{int'(res), int'(res_id), int'(res_err), int'(busy), cyc});
      end
   end

   task automatic clear_logs();
      gq.delete();
      gcq.delete();
      rq.delete();
      n_load = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_a = 1'b1;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_a = 1'b0;
      clear_logs();
   endtask

   task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b);
      a_in[i*4 +: 4] = a;
      b_in[i*4 +: 4] = b;
   endtask

   task automatic run_until(input string tag, input int n, input int budget);
      int b;
      b = 0;
      while (rq.size() < n && b < budget) begin
         @(posedge clk);
         #2;
         if (drop) req = req & ~gnt;
         b++;
      end
      chk({tag, "_nres"}, rq.size(), n);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_gnt"}, gnt, 0);
      chk({tag, "_load"}, mul_load, 0);
      chk({tag, "_mul_ab"}, {mul_a, mul_b}, 0);
      chk({tag, "_res"}, res, 0);
      chk({tag, "_res_id"}, res_id, 0);
      chk({tag, "_valid"}, res_valid, 0);
      chk({tag, "_err"}, res_err, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      int exp_id[5];
      int b;
      exp_id = '{0, 1, 2, 3, 0};
      rst_a   = 1'b1;
      req     = '0;
      a_in    = '0;
      b_in    = '0;
      drop    = 1'b1;
      mdl_dly = 4;
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_a = 1'b0;
      clear_logs();

      // Single requester, ready four cycles after load.
      set_ops(0, 4'd7, 4'd1);
      @(negedge clk);
      req = 4'b0001;
      run_until("t1", 1, 40);
      repeat (5) @(negedge clk);
      chk("t1_ngnt", gq.size(), 1);
      chk("t1_nload", n_load, 1);
      if (rq.size() >= 1 && gq.size() >= 1) begin
         chk("t1_gidx", gq[0], 0);
         chk("t1_res", rq[0].res, 7);
         chk("t1_id", rq[0].id, 0);
         chk("t1_err", rq[0].err, 0);
         chk("t1_lat", rq[0].cyc - gcq[0], 5);
      end

      // Two simultaneous requesters after reset: 0 then 2, back to back.
      do_reset();
      mdl_dly = 2;
      set_ops(0, 4'd3, 4'd5);
      set_ops(2, 4'd15, 4'd15);
      @(negedge clk);
      req = 4'b0101;
      run_until("t2", 2, 60);
      if (rq.size() >= 2 && gq.size() >= 2) begin
         chk("t2_g0", gq[0], 0);
         chk("t2_g1", gq[1], 2);
         chk("t2_res0", rq[0].res, 15);
         chk("t2_res1", rq[1].res, 225);
         chk("t2_id1", rq[1].id, 2);
         chk("t2_b2b", gcq[1], rq[0].cyc + 1);
      end

      // All four held high: rotation 0,1,2,3,0.
      do_reset();
      mdl_dly = 1;
      for (int i = 0; i < NR; i++) set_ops(i, 4'(i + 1), 4'd2);
      drop = 1'b0;
      @(negedge clk);
      req = 4'b1111;
      run_until("t3", 5, 80);
      req  = '0;
      drop = 1'b1;
      repeat (8) @(negedge clk);
      if (rq.size() >= 5 && gq.size() >= 5) begin
         for (int k = 0; k < 5; k++) begin
            chk($sformatf("t3_g%0d", k), gq[k], exp_id[k]);
            chk($sformatf("t3_id%0d", k), rq[k].id, exp_id[k]);
            chk($sformatf("t3_res%0d", k), rq[k].res, (exp_id[k] + 1) * 2);
         end
      end

      // Never ready: abort exactly TO cycles after WAIT entry.
      do_reset();
      mdl_dly = 0;
      set_ops(0, 4'd12, 4'd12);
      @(negedge clk);
      req = 4'b0001;
      run_until("t4", 1, 40);
      if (rq.size() >= 1 && gcq.size() >= 1) begin
         chk("t4_err", rq[0].err, 1);
         chk("t4_res", rq[0].res, 0);
         chk("t4_lat", rq[0].cyc - gcq[0], TO + 1);
         chk("t4_busy", rq[0].busy, 0);
      end

      // Ready on the timeout cycle wins.
      clear_logs();
      mdl_dly = TO;
      set_ops(0, 4'd9, 4'd13);
      @(negedge clk);
      req = 4'b0001;
      run_until("t5", 1, 40);
      if (rq.size() >= 1 && gcq.size() >= 1) begin
         chk("t5_err", rq[0].err, 0);
         chk("t5_res", rq[0].res, 117);
         chk("t5_lat", rq[0].cyc - gcq[0], TO + 1);
      end

      // Ready one cycle late: timeout, and the late ready in IDLE is ignored.
      repeat (4) @(negedge clk);
      clear_logs();
      mdl_dly = TO + 1;
      set_ops(0, 4'd10, 4'd10);
      @(negedge clk);
      req = 4'b0001;
      run_until("t5b", 1, 40);
      repeat (10) @(negedge clk);
      chk("t5b_nres", rq.size(), 1);
      if (rq.size() >= 1) begin
         chk("t5b_err", rq[0].err, 1);
         chk("t5b_res", rq[0].res, 0);
      end
      chk("t5b_valid_idle", res_valid, 0);

      // Reset in the middle of WAIT.
      repeat (4) @(negedge clk);
      clear_logs();
      mdl_dly = 10;
      set_ops(0, 4'd5, 4'd5);
      @(negedge clk);
      req = 4'b0001;
      b = 0;
      while (gq.size() == 0 && b < 20) begin
         @(posedge clk);
         #2;
         req = req & ~gnt;
         b++;
      end
      chk("t6_gnt", gq.size(), 1);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
      repeat (20) @(negedge clk);
      chk("t6_nres", rq.size(), 0);
      chk_reset_vals("t6");
      clear_logs();
      mdl_dly = 2;
      set_ops(1, 4'd6, 4'd7);
      @(negedge clk);
      req = 4'b0010;
      run_until("t6b", 1, 30);
      if (rq.size() >= 1 && gq.size() >= 1) begin
         chk("t6b_g", gq[0], 1);
         chk("t6b_res", rq[0].res, 42);
         chk("t6b_id", rq[0].id, 1);
      end

      repeat (4) @(negedge clk);
      chk("invariants", viol, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one seqmult.
REQ-002 Parameter TIMEOUT, default 15, max cycles spent in WAIT before abort.
REQ-003 Design SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_a  in  1  synchronous active-high reset.
REQ-006 req  in  N_REQ  per-requester request level.
REQ-007 a_in  in  4*N_REQ  operand A, requester i at bits [4i+3:4i].
REQ-008 b_in  in  4*N_REQ  operand B, same packing.
REQ-009 gnt  out  N_REQ  one-hot grant, one-cycle pulse.
REQ-010 res  out  8  product, or 0 on abort.
REQ-011 res_valid  out  1  one-cycle pulse; res, res_id and res_err valid.
REQ-012 res_id  out  clog2(N_REQ)  requester index owning res.
REQ-013 res_err  out  1  timeout flag, qualified by res_valid.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 mul_a, mul_b  out  4 each  operands to seqmult.
REQ-016 mul_load  out  1  start pulse to seqmult.
REQ-017 mul_op  in  8  seqmult product.
REQ-018 mul_ready  in  1  seqmult done.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE and WAIT; all outputs SHALL be registered.
REQ-020 IDLE, req != 0: select winner via round-robin; latch its operands into mul_a/mul_b; latch res_id; set gnt to the winner one-hot; go to ISSUE.
REQ-021 IDLE, req == 0: SHALL remain in IDLE with mul_load=0 and gnt=0.
REQ-022 Round-robin search SHALL start at (last+1) mod N_REQ, where last is the previous winner.
REQ-023 ISSUE SHALL last exactly one cycle with mul_load=1 and gnt high, then go to WAIT with cnt=0.
REQ-024 mul_load and gnt SHALL be 0 in every state other than ISSUE.
REQ-025 mul_a/mul_b SHALL hold stable from ISSUE until the FSM returns to IDLE.
REQ-026 WAIT: mul_ready SHALL be sampled every cycle; on mul_ready=1, res<=mul_op, res_err<=0, res_valid pulses one cycle, go to IDLE.
REQ-027 WAIT, no mul_ready: cnt SHALL increment.
REQ-028 WAIT, cnt==TIMEOUT-1 with no mul_ready: res<=0, res_err<=1, res_valid pulses, go to IDLE.
REQ-029 mul_ready in the same cycle as timeout SHALL win; the result is normal and err=0.
REQ-030 mul_ready outside WAIT SHALL be ignored.
REQ-031 A new arbitration SHALL be possible in the cycle res_valid is high (back-to-back).
REQ-032 A requester SHALL drop req after its gnt; a req held high is re-served at its next round-robin turn.
REQ-033 Latency from grant to res_valid SHALL be 2 + (WAIT cycles until mul_ready).

Reset
REQ-034 On rst_a=1 at a clock edge: state=IDLE, cnt=0, gnt=0, mul_load=0, mul_a=mul_b=0, res=0, res_id=0, res_valid=0, res_err=0, busy=0, last=N_REQ-1.
REQ-035 Reset in ISSUE or WAIT SHALL abort the operation with no res_valid pulse.

Structure
REQ-036 Package mult_arb_pkg SHALL hold the state enum, operand width (4), product width (8) and the default TIMEOUT.
REQ-037 Round-robin selection SHALL be the sub-module rr_pick (req, last -> one-hot and index, combinational).
REQ-038 seqmult SHALL stay outside this block and connect through the mul_* ports.

Verification
REQ-039 req=0001, a0=7, b0=1, model ready 4 cycles after load -> gnt=0001 once, mul_load one pulse, res=7, res_id=0, res_err=0.
REQ-040 req=0101 simultaneous, a2=15, b2=15 -> served 0 then 2; second result res=225, res_id=2.
REQ-041 req=1111 held continuously -> grant order 0,1,2,3,0, each res_valid tagged with the correct res_id.
REQ-042 Model never raises ready -> res_valid with res_err=1 and res=0 exactly TIMEOUT cycles after entering WAIT; busy then drops.
REQ-043 rst_a=1 mid-WAIT -> no res_valid, all outputs at reset values; next req=0010 is granted to requester 1 first.
REQ-044 mul_ready asserted on the timeout cycle -> res=mul_op, res_err=0.
